ex_div_unit: RTL and testbench

- Multi-cycle RV32M divide/remainder engine in the EX stage.
- Consumes the decoded instruction fields and operands presented at the output of the ID/EX pipeline register.
- Raises a stall back toward the ID/EX register and earlier stages until the result is ready.
- Delivers a 32-bit result with a one-cycle valid strobe for the EX/MEM register to capture.

---
 rtl/ex_div_unit.sv | 116 +++++++++++
 tb/tb_ex_div_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// RV32M divide/remainder engine for the EX stage: one restoring-division step per cycle.
// It stalls the front of the pipe until a registered result is presented with a one-cycle valid strobe.
module ex_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       ex_opcode,
   input  logic [6:0]       ex_func7,
   input  logic [2:0]       ex_func3,
   input  logic [WIDTH-1:0] ex_op1,
   input  logic [WIDTH-1:0] ex_op2,
   input  logic             flush,
   output logic             div_stall,
   output logic             div_valid,
   output logic             div_busy,
   output logic [WIDTH-1:0] div_result
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   rem_q, quo_q, dvs_q, res_q;
   logic               is_rem_q, neg_quo_q, neg_rem_q;

   logic               div_req, is_signed, is_rem, div_zero, ovf, start, special;
   logic [WIDTH-1:0]   a_mag, b_mag, spec_res;
   logic [WIDTH:0]     r_sh, diff;
   logic               sub_ok;
   logic [WIDTH-1:0]   rem_nx, quo_nx, fin;

   // Request decode and start conditions
   assign div_req   = (ex_opcode == 7'b0110011) & (ex_func7 == 7'b0000001) & ex_func3[2];
   assign is_signed = ~ex_func3[0];
   assign is_rem    = ex_func3[1];
   assign div_zero  = (ex_op2 == '0);
   assign ovf       = is_signed & (ex_op1 == MIN_NEG) & (ex_op2 == '1);
   assign special   = div_zero | ovf;
   assign start     = (state_q == S_IDLE) & div_req & ~flush;

   assign a_mag    = (is_signed & ex_op1[WIDTH-1]) ? -ex_op1 : ex_op1;
   assign b_mag    = (is_signed & ex_op2[WIDTH-1]) ? -ex_op2 : ex_op2;
   assign spec_res = div_zero ? (is_rem ? ex_op1 : '1) : (is_rem ? '0 : MIN_NEG);

   // Restoring step: the shifted partial remainder needs one extra bit before the trial subtract
   assign r_sh   = {rem_q, quo_q[WIDTH-1]};
   assign diff   = r_sh - {1'b0, dvs_q};
   assign sub_ok = (r_sh >= {1'b0, dvs_q});
   assign rem_nx = sub_ok ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
   assign quo_nx = {quo_q[WIDTH-2:0], sub_ok};
   assign fin    = is_rem_q ? (neg_rem_q ? -rem_nx : rem_nx)
                            : (neg_quo_q ? -quo_nx : quo_nx);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = special ? S_DONE : S_BUSY;
         S_BUSY:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_comb begin
      div_stall = div_req & (state_q != S_DONE) & ~flush & rst;
      div_valid = (state_q == S_DONE) & ~flush;
      div_busy  = (state_q == S_BUSY);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         res_q     <= '0;
         is_rem_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (start) begin
         is_rem_q  <= is_rem;
         neg_quo_q <= is_signed & ~is_rem & (ex_op1[WIDTH-1] ^ ex_op2[WIDTH-1]);
         neg_rem_q <= is_signed & is_rem & ex_op1[WIDTH-1];
         if (special) begin
            res_q <= spec_res;
         end else begin
            quo_q <= a_mag;
            rem_q <= '0;
            dvs_q <= b_mag;
            cnt_q <= CNT_W'(WIDTH);
         end
      end else if (state_q == S_BUSY) begin
         if (flush) begin
            cnt_q <= '0;
         end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) res_q <= fin;
         end
      end
   end

   assign div_result = res_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: a vector table run back-to-back, then flush, reset and random cases.
// Expected results go into a queue when an instruction is driven and are popped on div_valid.
module tb_ex_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  ex_opcode, ex_func7;
   logic [2:0]  ex_func3;
   logic [31:0] ex_op1, ex_op2;
   logic        flush;
   logic        div_stall, div_valid, div_busy;
   logic [31:0] div_result;

   int chks = 0;
   int errs = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl[14];

   ex_div_unit dut (
      .clk(clk), .rst(rst), .ex_opcode(ex_opcode), .ex_func7(ex_func7),
      .ex_func3(ex_func3), .ex_op1(ex_op1), .ex_op2(ex_op2), .flush(flush),
      .div_stall(div_stall), .div_valid(div_valid), .div_busy(div_busy),
      .div_result(div_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic drive_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      ex_opcode = 7'b0110011;
      ex_func7  = 7'b0000001;
      ex_func3  = f3;
      ex_op1    = a;
      ex_op2    = b;
   endtask

   task automatic drive_add();
      ex_opcode = 7'b0110011;
      ex_func7  = 7'b0000000;
      ex_func3  = 3'b000;
      ex_op1    = 32'd1;
      ex_op2    = 32'd2;
   endtask

   // Counts cycles from the first cycle the instruction sits in EX until div_valid
   task automatic wait_result(input int lat, input string nm);
      int n = 0;
      int st = 0;
      bit got = 0;
      logic [31:0] e;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         if (n == 2) chk({nm, "_busy"}, {31'd0, div_busy}, {31'd0, lat > 2});
         if (div_valid) got = 1;
         else if (div_stall) st++;
      end
      chk({nm, "_got_valid"}, {31'd0, got}, 32'd1);
      if (got) begin
         chk({nm, "_latency"}, n, lat);
         chk({nm, "_stall_cycles"}, st, lat - 1);
         chk({nm, "_stall_at_valid"}, {31'd0, div_stall}, 32'd0);
         if (exp_q.size() == 0) chk({nm, "_queue"}, 32'd0, 32'd1);
         else begin
            e = exp_q.pop_front();
            chk({nm, "_result"}, div_result, e);
         end
      end
   endtask

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string nm);
      @(posedge clk); #1;
      drive_div(f3, a, b);
      exp_q.push_back(exp);
      wait_result(lat, nm);
   endtask

   task automatic idle_cycles(input int k, input string nm);
      for (int i = 0; i < k; i++) begin
         @(posedge clk); #1;
         drive_add();
         @(negedge clk);
         chk({nm, "_stall"}, {31'd0, div_stall}, 32'd0);
         chk({nm, "_valid"}, {31'd0, div_valid}, 32'd0);
      end
   endtask

   initial begin
      tbl[0]  = '{3'b101, 32'd100, 32'd7, 32'd14, 34};
      tbl[1]  = '{3'b111, 32'd100, 32'd7, 32'd2, 34};
      tbl[2]  = '{3'b100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 34};
      tbl[3]  = '{3'b110, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 34};
      tbl[4]  = '{3'b110, 32'd20, 32'hFFFFFFFD, 32'd2, 34};
      tbl[5]  = '{3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 2};
      tbl[6]  = '{3'b111, 32'd5, 32'd0, 32'd5, 2};
      tbl[7]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
      tbl[8]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2};
      tbl[9]  = '{3'b101, 32'd50, 32'd5, 32'd10, 34};
      tbl[10] = '{3'b111, 32'd50, 32'd7, 32'd1, 34};
      tbl[11] = '{3'b101, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34};
      tbl[12] = '{3'b100, 32'h80000000, 32'd2, 32'hC0000000, 34};
      tbl[13] = '{3'b111, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};

      rst   = 1'b0;
      flush = 1'b0;
      drive_div(3'b100, 32'hFFFFFFEC, 32'd3);
      @(negedge clk);
      @(negedge clk);
      chk("reset_stall", {31'd0, div_stall}, 32'd0);
      chk("reset_valid", {31'd0, div_valid}, 32'd0);
      chk("reset_busy", {31'd0, div_busy}, 32'd0);
      chk("reset_result", div_result, 32'd0);
      drive_add();
      @(posedge clk); #1;
      rst = 1'b1;

      idle_cycles(2, "add_idle");

      // Table runs back-to-back: each op is driven the cycle after the previous valid
      for (int i = 0; i < 14; i++)
         run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, $sformatf("vec%0d", i));

      // Back-to-back with an ADD between them
      run_op(3'b101, 32'd50, 32'd5, 32'd10, 34, "b2b_divu");
      idle_cycles(1, "b2b_add");
      run_op(3'b111, 32'd50, 32'd7, 32'd1, 34, "b2b_remu");

      // Flush in BUSY cycle 10
      @(posedge clk); #1;
      drive_div(3'b101, 32'hFFFFFFFF, 32'd1);
      for (int i = 0; i < 10; i++) @(negedge clk);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", {31'd0, div_stall}, 32'd0);
      chk("flush_valid", {31'd0, div_valid}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      drive_add();
      @(negedge clk);
      chk("flush_idle_busy", {31'd0, div_busy}, 32'd0);
      begin
         int seen = 0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (div_valid) seen++;
         end
         chk("flush_no_valid", seen, 0);
      end
      run_op(3'b101, 32'd9, 32'd3, 32'd3, 34, "after_flush");

      // Asynchronous reset in BUSY cycle 20, then restart of the same DIV
      @(posedge clk); #1;
      drive_div(3'b100, 32'd100, 32'hFFFFFFF9);
      for (int i = 0; i < 21; i++) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_stall", {31'd0, div_stall}, 32'd0);
      chk("midrst_valid", {31'd0, div_valid}, 32'd0);
      chk("midrst_busy", {31'd0, div_busy}, 32'd0);
      chk("midrst_result", div_result, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.push_back(32'hFFFFFFF2);
      wait_result(34, "restart");

      // Random operands checked against the language's own division
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a, b, e;
         logic [2:0]  f3;
         a  = $urandom;
         b  = $urandom_range(1, 65535);
         f3 = 3'b100 | 3'(i);
         case (i)
            0: e = 32'($signed(a) / $signed(b));
            1: e = a / b;
            2: e = 32'($signed(a) % $signed(b));
            default: e = a % b;
         endcase
         run_op(f3, a, b, e, 34, $sformatf("rand%0d", i));
      end

      idle_cycles(2, "end_idle");
      $display("CHECKS %0d ERRORS %0d", chks, errs);
      $finish;
   end

endmodule
